plic_intr_src_conditioner: RTL and testbench



---
 rtl/plic_src_pkg.sv | 19 +
 rtl/plic_src_filter_slice.sv | 104 ++++++++++
 rtl/plic_intr_src_conditioner.sv | 41 ++++
 tb/tb_plic_intr_src_conditioner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/plic_src_pkg.sv
// Shared defaults and types for the PLIC interrupt-source conditioner.
package plic_src_pkg;

    // Default synchronizer depth (legal range >= 2).
    localparam int unsigned DefSyncStages = 2;

    // Default number of consecutive stable cycles before the filtered level moves.
    localparam int unsigned DefFilterCycles = 4;

    // Default width of each per-source rise counter.
    localparam int unsigned DefCntWidth = 8;

    // Default number of sources; matches the PLIC NumSrc of the SoC.
    localparam int unsigned DefNumSrc = 2;

    // Per-source rise counter at the default width.
    typedef logic [DefCntWidth-1:0] src_cnt_t;

endpackage : plic_src_pkg

// File: rtl/plic_src_filter_slice.sv
// One interrupt source: polarity normalisation, synchronizer, stability
// filter, enable gating, rise detection and a saturating rise counter.
module plic_src_filter_slice
    import plic_src_pkg::*;
#(
    parameter int unsigned sync_stages_p   = DefSyncStages,
    parameter int unsigned filter_cycles_p = DefFilterCycles,
    parameter int unsigned cnt_width_p     = DefCntWidth,
    parameter bit          active_low_p    = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   intr_async_i,
    input  logic                   en_i,
    input  logic                   clear_i,
    output logic                   intr_src_o,
    output logic                   rise_o,
    output logic [cnt_width_p-1:0] count_o
);

    localparam int unsigned StabW = $clog2(filter_cycles_p + 1);
    localparam logic [StabW-1:0] StabMax = StabW'(filter_cycles_p - 1);

    // Normalised (active-high) raw line.
    logic norm;
    assign norm = intr_async_i ^ active_low_p;

    // Synchronizer chain; resets to the inactive level so an active-low line
    // held high through reset does not look like an interrupt.
    (* ASYNC_REG = "TRUE" *) logic [sync_stages_p-1:0] sync_q;
    logic [sync_stages_p-1:0] sync_d;
    logic                     synced;

    // Filter, delay and counter state.
    logic                   filt_q, filt_d;
    logic [StabW-1:0]       stab_q, stab_d;
    logic                   filt_dly_q, filt_dly_d;
    logic [cnt_width_p-1:0] cnt_q, cnt_d;
    logic                   cnt_sat;

    // Shift the normalised line through the synchronizer.
    always_comb begin
        sync_d = {sync_q[sync_stages_p-2:0], norm};
    end

    assign synced = sync_q[sync_stages_p-1];

    // Stability filter: the level moves only after filter_cycles_p
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        stab_d = stab_q;
        if (synced == filt_q) begin
            stab_d = '0;
        end else if (stab_q == StabMax) begin
            filt_d = synced;
            stab_d = '0;
        end else begin
            stab_d = stab_q + StabW'(1);
        end
    end

    // Enable gates only the outputs, never the filter, so re-enabling a
    // source that is already high shows the level without a rise pulse.
    always_comb begin
        filt_dly_d = filt_q;
        intr_src_o = filt_q & en_i;
        rise_o     = en_i & filt_q & ~filt_dly_q;
    end

    assign cnt_sat = &cnt_q;

    // Saturating rise counter; a clear coinciding with a rise keeps that rise.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i && rise_o) begin
            cnt_d = cnt_width_p'(1);
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (rise_o && !cnt_sat) begin
            cnt_d = cnt_q + cnt_width_p'(1);
        end
    end

    assign count_o = cnt_q;

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            filt_q     <= 1'b0;
            stab_q     <= '0;
            filt_dly_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            stab_q     <= stab_d;
            filt_dly_q <= filt_dly_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule : plic_src_filter_slice

// File: rtl/plic_intr_src_conditioner.sv
// Conditions raw asynchronous interrupt lines into clean active-high levels
// for the PLIC gateway, plus per-source rise pulses and rise counters.
module plic_intr_src_conditioner
    import plic_src_pkg::*;
#(
    parameter int unsigned          num_src_p         = DefNumSrc,
    parameter int unsigned          sync_stages_p     = DefSyncStages,
    parameter int unsigned          filter_cycles_p   = DefFilterCycles,
    parameter logic [num_src_p-1:0] active_low_mask_p = '0,
    parameter int unsigned          cnt_width_p       = DefCntWidth
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [num_src_p-1:0]             intr_async_i,
    input  logic [num_src_p-1:0]             en_i,
    input  logic [num_src_p-1:0]             clear_i,
    output logic [num_src_p-1:0]             intr_src_o,
    output logic [num_src_p-1:0]             rise_o,
    output logic [num_src_p*cnt_width_p-1:0] count_o
);

    // One independent slice per source; counters packed source-major.
    for (genvar i = 0; i < num_src_p; i++) begin : g_src
        plic_src_filter_slice #(
            .sync_stages_p   (sync_stages_p),
            .filter_cycles_p (filter_cycles_p),
            .cnt_width_p     (cnt_width_p),
            .active_low_p    (active_low_mask_p[i])
        ) u_slice (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .intr_async_i (intr_async_i[i]),
            .en_i         (en_i[i]),
            .clear_i      (clear_i[i]),
            .intr_src_o   (intr_src_o[i]),
            .rise_o       (rise_o[i]),
            .count_o      (count_o[i*cnt_width_p +: cnt_width_p])
        );
    end

endmodule : plic_intr_src_conditioner

// File: tb/tb_plic_intr_src_conditioner.sv
// Scoreboard bench: stimulus pushes expected rise events (source, cycle,
// count after the rise); a monitor pops one per observed rise_o pulse.
module tb_plic_intr_src_conditioner;

    localparam logic [1:0] Mask = 2'b10;

    logic        clk;
    logic        rst_ni;
    logic [1:0]  intr;
    logic [1:0]  en;
    logic [1:0]  clr;
    logic [1:0]  intr_src;
    logic [1:0]  rise;
    logic [15:0] count;

    typedef struct {
        int src;
        int cyc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   model_cnt[2];
    bit   pend[2];
    int   pend_cnt[2];

    plic_intr_src_conditioner #(
        .num_src_p         (2),
        .sync_stages_p     (2),
        .filter_cycles_p   (4),
        .active_low_mask_p (Mask),
        .cnt_width_p       (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .intr_async_i (intr),
        .en_i         (en),
        .clear_i      (clr),
        .intr_src_o   (intr_src),
        .rise_o       (rise),
        .count_o      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive the normalised (active-high) level of one source.
    task automatic set_lvl(input int s, input bit v);
        intr[s] = v ^ Mask[s];
    endtask

    // Expect a rise on source s, 6 cycles after the current negedge.
    task automatic expect_rise(input int s, input bit with_clear);
        exp_t e;
        if (with_clear) model_cnt[s] = 1;
        else if (model_cnt[s] < 255) model_cnt[s] = model_cnt[s] + 1;
        e.src = s;
        e.cyc = cyc + 6;
        e.cnt = model_cnt[s];
        exp_q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int cnt_of(input int s);
        return (s == 0) ? int'(count[7:0]) : int'(count[15:8]);
    endfunction

    // Monitor: every rise_o pulse must match the head of the scoreboard,
    // and the counter is checked on the following cycle.
    initial begin
        pend = '{0, 0};
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                for (int s = 0; s < 2; s++) begin
                    if (pend[s]) begin
                        check($sformatf("count_after_rise_src%0d", s), cnt_of(s), pend_cnt[s]);
                        pend[s] = 0;
                    end
                end
                for (int s = 0; s < 2; s++) begin
                    if (rise[s]) begin
                        check($sformatf("rise_expected_src%0d", s), int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("rise_src", s, e.src);
                            check("rise_cycle", cyc, e.cyc);
                            check("level_at_rise", int'(intr_src[s]), 1);
                            pend[s]     = 1;
                            pend_cnt[s] = e.cnt;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        rst_ni       = 1'b0;
        intr         = Mask;   // both inactive; active-low line held high
        en           = 2'b11;
        clr          = 2'b00;
        #2;
        check("reset_intr_src", int'(intr_src), 0);
        check("reset_rise", int'(rise), 0);
        check("reset_count", int'(count), 0);
        wait_neg(3);
        rst_ni = 1'b1;
        wait_neg(8);
        check("active_low_idle", int'(intr_src), 0);

        // Clean assertion on source 0.
        set_lvl(0, 1);
        expect_rise(0, 0);
        wait_neg(5);
        check("clean_not_yet", int'(intr_src[0]), 0);
        wait_neg(5);
        check("clean_level_high", int'(intr_src[0]), 1);
        set_lvl(0, 0);
        wait_neg(5);
        check("deassert_not_yet", int'(intr_src[0]), 1);
        wait_neg(1);
        check("deassert_low", int'(intr_src[0]), 0);
        wait_neg(4);

        // Glitch rejection on active-low source 1: 3 cycles dropped.
        set_lvl(1, 1);
        wait_neg(3);
        set_lvl(1, 0);
        wait_neg(10);
        check("glitch3_level", int'(intr_src[1]), 0);
        check("glitch3_count", cnt_of(1), 0);
        // 4 cycles pass the filter.
        set_lvl(1, 1);
        expect_rise(1, 0);
        wait_neg(4);
        set_lvl(1, 0);
        wait_neg(12);
        check("pulse4_level_back_low", int'(intr_src[1]), 0);
        check("pulse4_count", cnt_of(1), 1);

        // Enable interaction: filtered high while disabled.
        en[0] = 1'b0;
        set_lvl(0, 1);
        wait_neg(10);
        check("disabled_level", int'(intr_src[0]), 0);
        check("disabled_count", cnt_of(0), model_cnt[0]);
        en[0] = 1'b1;
        #1;
        check("enabled_level", int'(intr_src[0]), 1);
        wait_neg(3);
        set_lvl(0, 0);
        wait_neg(10);
        // Clear coinciding with a new rise.
        set_lvl(0, 1);
        expect_rise(0, 1);
        wait_neg(6);
        clr[0] = 1'b1;
        wait_neg(1);
        clr[0] = 1'b0;
        wait_neg(3);
        set_lvl(0, 0);
        wait_neg(10);
        // Plain clear.
        clr[0] = 1'b1;
        wait_neg(1);
        clr[0] = 1'b0;
        model_cnt[0] = 0;
        check("clear_count", cnt_of(0), 0);

        // Saturation: 300 rises on source 0.
        for (int k = 0; k < 300; k++) begin
            set_lvl(0, 1);
            expect_rise(0, 0);
            wait_neg(7);
            set_lvl(0, 0);
            wait_neg(7);
        end
        check("saturated_count", cnt_of(0), 255);
        check("src1_count_untouched", cnt_of(1), 1);

        // Reset while the filter counter sits at 2.
        set_lvl(0, 1);
        wait_neg(4);
        rst_ni = 1'b0;
        #1;
        check("midreset_intr_src", int'(intr_src), 0);
        check("midreset_rise", int'(rise), 0);
        check("midreset_count", int'(count), 0);
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        wait_neg(2);
        rst_ni = 1'b1;
        expect_rise(0, 0);
        wait_neg(5);
        check("post_reset_not_yet", int'(intr_src[0]), 0);
        wait_neg(6);
        check("post_reset_level", int'(intr_src[0]), 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_plic_intr_src_conditioner
